// File: rtl/inst_issue_queue.sv
// inst_issue_queue: circular instruction buffer between fetch and dual-issue
// decode. Accepts up to two entries per cycle, presents the two oldest
// entries as the inst1/inst2 pair, retires zero/one/two per cycle, and holds
// the delay-slot flag that survives single-issue boundaries.
module inst_issue_queue #(
  parameter int DEPTH  = 16,
  parameter int CORR_W = 88
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              push1_i,
  input  logic              push2_i,
  input  logic [31:0]       inst1_i,
  input  logic [31:0]       inst2_i,
  input  logic [31:0]       addr1_i,
  input  logic [31:0]       addr2_i,
  input  logic [CORR_W-1:0] corr1_i,
  input  logic [CORR_W-1:0] corr2_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [31:0]       inst1_o,
  output logic [31:0]       inst2_o,
  output logic [31:0]       addr1_o,
  output logic [31:0]       addr2_o,
  output logic [CORR_W-1:0] corr1_o,
  output logic [CORR_W-1:0] corr2_o,
  output logic              issue_en_o,
  output logic              is_in_delayslot_o,
  input  logic              issued_i,
  input  logic              issue_mode_i,
  input  logic              ninst_in_delayslot_i
);

  localparam int PW = $clog2(DEPTH);

  // Count thresholds sized to the count register to keep compares width-exact.
  localparam logic [PW:0] CNT_ZERO = '0;
  localparam logic [PW:0] CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0] CNT_TWO  = (PW+1)'(2);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH-2);

  // Entry storage; data only, never reset.
  logic [31:0]       inst_mem [DEPTH];
  logic [31:0]       addr_mem [DEPTH];
  logic [CORR_W-1:0] corr_mem [DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          ds_q, ds_d;

  logic [PW-1:0] rd_ptr_nx;
  logic [PW-1:0] wr_ptr_nx;
  logic          push_ok;
  logic [1:0]    push_n;
  logic [1:0]    req_n;
  logic [1:0]    pop_n;
  logic          q_nonempty;

  assign rd_ptr_nx  = rd_ptr_q + PW'(1);
  assign wr_ptr_nx  = wr_ptr_q + PW'(1);
  assign q_nonempty = (count_q != CNT_ZERO);

  // full_o looks only at registered count so a same-cycle pop never relaxes it
  // and decode handshakes cannot form a loop back into fetch.
  assign full_o            = (count_q > CNT_FULL);
  assign empty_o           = ~q_nonempty;
  assign issue_en_o        = q_nonempty;
  assign is_in_delayslot_o = ds_q;

  // A push is taken whole or dropped whole; slot 2 alone is meaningless.
  assign push_ok = push1_i & ~full_o & ~flush_i;
  assign push_n  = push_ok ? (push2_i ? 2'd2 : 2'd1) : 2'd0;

  // Retire count: decode's request clipped to what is really stored, so a
  // dual issue against a padded NOP retires only the real entry.
  always_comb begin
    req_n = 2'd0;
    if (issued_i) begin
      req_n = issue_mode_i ? 2'd2 : 2'd1;
    end
    pop_n = req_n;
    if (!q_nonempty) begin
      pop_n = 2'd0;
    end else if ((count_q == CNT_ONE) && (req_n == 2'd2)) begin
      pop_n = 2'd1;
    end
  end

  // Next-state for pointers, count and delay-slot flag; flush wins over all.
  always_comb begin
    rd_ptr_d = rd_ptr_q + PW'(pop_n);
    wr_ptr_d = wr_ptr_q + PW'(push_n);
    count_d  = count_q + (PW+1)'(push_n) - (PW+1)'(pop_n);
    ds_d     = ds_q;
    if (issued_i && q_nonempty) begin
      ds_d = ninst_in_delayslot_i;
    end
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      ds_d     = 1'b0;
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ds_q     <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ds_q     <= ds_d;
    end
  end

  // Entry writes: slot 1 at wr_ptr, slot 2 at wr_ptr+1 (wraps modulo DEPTH).
  always_ff @(posedge clk) begin
    if (push_ok && !rst) begin
      inst_mem[wr_ptr_q] <= inst1_i;
      addr_mem[wr_ptr_q] <= addr1_i;
      corr_mem[wr_ptr_q] <= corr1_i;
      if (push2_i) begin
        inst_mem[wr_ptr_nx] <= inst2_i;
        addr_mem[wr_ptr_nx] <= addr2_i;
        corr_mem[wr_ptr_nx] <= corr2_i;
      end
    end
  end

  // Presentation: head and head+1, zeros (a NOP in slot 2) where no entry exists.
  always_comb begin
    inst1_o = '0;
    addr1_o = '0;
    corr1_o = '0;
    inst2_o = '0;
    addr2_o = '0;
    corr2_o = '0;
    if (q_nonempty) begin
      inst1_o = inst_mem[rd_ptr_q];
      addr1_o = addr_mem[rd_ptr_q];
      corr1_o = corr_mem[rd_ptr_q];
    end
    if (count_q >= CNT_TWO) begin
      inst2_o = inst_mem[rd_ptr_nx];
      addr2_o = addr_mem[rd_ptr_nx];
      corr2_o = corr_mem[rd_ptr_nx];
    end
  end

endmodule

// File: tb/tb_inst_issue_queue.sv
// Directed bench for inst_issue_queue (DEPTH=16, CORR_W=88).
module tb_inst_issue_queue;

  localparam int DEPTH  = 16;
  localparam int CORR_W = 88;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush_i;
  logic              push1_i, push2_i;
  logic [31:0]       inst1_i, inst2_i, addr1_i, addr2_i;
  logic [CORR_W-1:0] corr1_i, corr2_i;
  logic              full_o, empty_o;
  logic [31:0]       inst1_o, inst2_o, addr1_o, addr2_o;
  logic [CORR_W-1:0] corr1_o, corr2_o;
  logic              issue_en_o, is_in_delayslot_o;
  logic              issued_i, issue_mode_i, ninst_in_delayslot_i;

  int nvec = 0;
  int nerr = 0;

  inst_issue_queue #(.DEPTH(DEPTH), .CORR_W(CORR_W)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .push1_i(push1_i), .push2_i(push2_i),
    .inst1_i(inst1_i), .inst2_i(inst2_i),
    .addr1_i(addr1_i), .addr2_i(addr2_i),
    .corr1_i(corr1_i), .corr2_i(corr2_i),
    .full_o(full_o), .empty_o(empty_o),
    .inst1_o(inst1_o), .inst2_o(inst2_o),
    .addr1_o(addr1_o), .addr2_o(addr2_o),
    .corr1_o(corr1_o), .corr2_o(corr2_o),
    .issue_en_o(issue_en_o), .is_in_delayslot_o(is_in_delayslot_o),
    .issued_i(issued_i), .issue_mode_i(issue_mode_i),
    .ninst_in_delayslot_i(ninst_in_delayslot_i)
  );

  always #5 clk = ~clk;

  function automatic logic [CORR_W-1:0] corr_of(input logic [31:0] i, input logic [31:0] a);
    return {a, i, 24'hC0FFEE};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_push(input logic p1, input logic p2,
                          input logic [31:0] i1, input logic [31:0] a1,
                          input logic [31:0] i2, input logic [31:0] a2);
    push1_i = p1;
    push2_i = p2;
    inst1_i = i1;
    addr1_i = a1;
    corr1_i = corr_of(i1, a1);
    inst2_i = i2;
    addr2_i = a2;
    corr2_i = corr_of(i2, a2);
  endtask

  task automatic set_iss(input logic iss, input logic mode, input logic nds);
    issued_i             = iss;
    issue_mode_i         = mode;
    ninst_in_delayslot_i = nds;
  endtask

  task automatic clr();
    set_push(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    set_iss(1'b0, 1'b0, 1'b0);
    flush_i = 1'b0;
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, ".empty"}, empty_o, 1'b1);
    chk({tag, ".issue_en"}, issue_en_o, 1'b0);
    chk({tag, ".inst1"}, inst1_o, 32'h0);
  endtask

  int q[$];
  int nv;
  logic pushed;

  initial begin
    rst = 1'b1;
    clr();
    cyc();
    cyc();
    // Reset state
    chk("rst.full", full_o, 1'b0);
    chk("rst.empty", empty_o, 1'b1);
    chk("rst.issue_en", issue_en_o, 1'b0);
    chk("rst.ds", is_in_delayslot_o, 1'b0);
    chk("rst.inst1", inst1_o, 32'h0);
    chk("rst.inst2", inst2_o, 32'h0);
    chk("rst.addr1", addr1_o, 32'h0);
    chk("rst.corr2", corr2_o, 128'h0);
    rst = 1'b0;

    // Single pair, then dual issue
    set_push(1'b1, 1'b1, 32'h24010001, 32'hBFC00000, 32'h24020002, 32'hBFC00004);
    cyc();
    clr();
    chk("pair.inst1", inst1_o, 32'h24010001);
    chk("pair.addr1", addr1_o, 32'hBFC00000);
    chk("pair.corr1", corr1_o, {40'h0, 32'hBFC00000, 32'h24010001, 24'hC0FFEE});
    chk("pair.inst2", inst2_o, 32'h24020002);
    chk("pair.addr2", addr2_o, 32'hBFC00004);
    chk("pair.corr2", corr2_o, {40'h0, 32'hBFC00004, 32'h24020002, 24'hC0FFEE});
    chk("pair.issue_en", issue_en_o, 1'b1);
    chk("pair.empty", empty_o, 1'b0);
    set_iss(1'b1, 1'b1, 1'b0);
    cyc();
    clr();
    chk_empty("pair.after");

    // Odd count with NOP pad
    set_push(1'b1, 1'b1, 32'h11111111, 32'h100, 32'h22222222, 32'h104);
    cyc();
    set_push(1'b1, 1'b0, 32'h33333333, 32'h108, 32'h0, 32'h0);
    cyc();
    clr();
    chk("odd.inst1", inst1_o, 32'h11111111);
    chk("odd.inst2", inst2_o, 32'h22222222);
    set_iss(1'b1, 1'b1, 1'b0);
    cyc();
    chk("odd.c.inst1", inst1_o, 32'h33333333);
    chk("odd.c.addr1", addr1_o, 32'h108);
    chk("odd.c.inst2", inst2_o, 32'h0);
    chk("odd.c.addr2", addr2_o, 32'h0);
    chk("odd.c.corr2", corr2_o, 128'h0);
    chk("odd.c.empty", empty_o, 1'b0);
    cyc();
    chk_empty("odd.drained");
    cyc();
    clr();
    chk_empty("odd.issue_on_empty");
    chk("odd.full", full_o, 1'b0);
    // Slot 2 without slot 1 is ignored
    set_push(1'b0, 1'b1, 32'h0, 32'h0, 32'h44444444, 32'h10C);
    cyc();
    clr();
    chk_empty("push2only");

    // Fill to 15, drop at full, single issue with refill across the wrap
    for (int k = 0; k < 14; k += 2) begin
      set_push(1'b1, 1'b1, 32'hA0000000 + k, 32'h2000 + 4 * k,
               32'hA0000000 + k + 1, 32'h2000 + 4 * (k + 1));
      cyc();
      q.push_back(k);
      q.push_back(k + 1);
    end
    clr();
    chk("fill14.full", full_o, 1'b0);
    set_push(1'b1, 1'b0, 32'hA000000E, 32'h2038, 32'h0, 32'h0);
    cyc();
    clr();
    q.push_back(14);
    chk("fill15.full", full_o, 1'b1);
    set_push(1'b1, 1'b1, 32'hDEAD0000, 32'h9000, 32'hDEAD0001, 32'h9004);
    cyc();
    clr();
    chk("drop.full", full_o, 1'b1);
    chk("drop.inst1", inst1_o, 32'hA0000000);
    nv = 15;
    for (int i = 0; i < 15; i++) begin
      chk("wrap.inst1", inst1_o, 32'hA0000000 + q[0]);
      chk("wrap.addr1", addr1_o, 32'h2000 + 4 * q[0]);
      chk("wrap.full", full_o, (q.size() > DEPTH - 2));
      set_iss(1'b1, 1'b0, 1'b0);
      pushed = ~full_o;
      if (pushed) begin
        set_push(1'b1, 1'b1, 32'hA0000000 + nv, 32'h2000 + 4 * nv,
                 32'hA0000000 + nv + 1, 32'h2000 + 4 * (nv + 1));
      end else begin
        set_push(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      end
      cyc();
      void'(q.pop_front());
      if (pushed) begin
        q.push_back(nv);
        q.push_back(nv + 1);
        nv += 2;
      end
    end
    clr();
    chk("wrap.remaining", q.size(), 14);
    for (int i = 0; i < 7; i++) begin
      chk("drain.inst1", inst1_o, 32'hA0000000 + q[0]);
      chk("drain.inst2", inst2_o, 32'hA0000000 + q[1]);
      set_iss(1'b1, 1'b1, 1'b0);
      cyc();
      void'(q.pop_front());
      void'(q.pop_front());
    end
    clr();
    chk_empty("drain.done");

    // Stall hold with four entries
    set_push(1'b1, 1'b1, 32'hE0000000, 32'h300, 32'hE0000001, 32'h304);
    cyc();
    set_push(1'b1, 1'b1, 32'hE0000002, 32'h308, 32'hE0000003, 32'h30C);
    cyc();
    clr();
    for (int i = 0; i < 5; i++) begin
      chk("stall.inst1", inst1_o, 32'hE0000000);
      chk("stall.inst2", inst2_o, 32'hE0000001);
      cyc();
    end
    chk("stall.full", full_o, 1'b0);
    set_iss(1'b1, 1'b0, 1'b0);
    cyc();
    clr();
    chk("stall.pop.inst1", inst1_o, 32'hE0000001);
    chk("stall.pop.addr1", addr1_o, 32'h304);
    chk("stall.pop.inst2", inst2_o, 32'hE0000002);
    set_iss(1'b1, 1'b1, 1'b0);
    cyc();
    chk("stall.last.inst1", inst1_o, 32'hE0000003);
    chk("stall.last.inst2", inst2_o, 32'h0);
    set_iss(1'b1, 1'b0, 1'b0);
    cyc();
    clr();
    chk_empty("stall.done");

    // Delay slot tracking
    set_push(1'b1, 1'b1, 32'h10000003, 32'h400, 32'h24030003, 32'h404);
    cyc();
    set_push(1'b1, 1'b1, 32'h24040004, 32'h408, 32'h24050005, 32'h40C);
    cyc();
    clr();
    chk("ds.branch", inst1_o, 32'h10000003);
    chk("ds.before", is_in_delayslot_o, 1'b0);
    set_iss(1'b1, 1'b0, 1'b1);
    cyc();
    clr();
    chk("ds.set", is_in_delayslot_o, 1'b1);
    chk("ds.slot.inst1", inst1_o, 32'h24030003);
    set_iss(1'b0, 1'b0, 1'b0);
    cyc();
    chk("ds.hold", is_in_delayslot_o, 1'b1);
    set_iss(1'b1, 1'b0, 1'b0);
    cyc();
    clr();
    chk("ds.clear", is_in_delayslot_o, 1'b0);
    chk("ds.next.inst1", inst1_o, 32'h24040004);

    // Build count 6 with ds=1, pushing and popping together
    set_push(1'b1, 1'b1, 32'h50000001, 32'h500, 32'h50000002, 32'h504);
    set_iss(1'b1, 1'b0, 1'b1);
    cyc();
    clr();
    chk("pp.inst1", inst1_o, 32'h24050005);
    chk("pp.inst2", inst2_o, 32'h50000001);
    chk("pp.ds", is_in_delayslot_o, 1'b1);
    set_push(1'b1, 1'b1, 32'h50000003, 32'h508, 32'h50000004, 32'h50C);
    cyc();
    set_push(1'b1, 1'b0, 32'h50000005, 32'h510, 32'h0, 32'h0);
    cyc();
    clr();
    chk("pre.flush.full", full_o, 1'b0);

    // Flush collides with push and issue
    flush_i = 1'b1;
    set_push(1'b1, 1'b1, 32'h66666666, 32'h600, 32'h77777777, 32'h604);
    set_iss(1'b1, 1'b1, 1'b1);
    cyc();
    clr();
    chk_empty("flush");
    chk("flush.ds", is_in_delayslot_o, 1'b0);
    chk("flush.full", full_o, 1'b0);
    cyc();
    chk_empty("flush.absent");
    set_push(1'b1, 1'b1, 32'h88888888, 32'h700, 32'h99999999, 32'h704);
    cyc();
    clr();
    chk("postflush.inst1", inst1_o, 32'h88888888);
    chk("postflush.inst2", inst2_o, 32'h99999999);

    // Reset mid-operation discards entries and a concurrent push
    rst = 1'b1;
    set_push(1'b1, 1'b1, 32'hAAAA0000, 32'h800, 32'hAAAA0001, 32'h804);
    cyc();
    rst = 1'b0;
    clr();
    chk_empty("midrst");
    chk("midrst.inst2", inst2_o, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
